// File: rtl/usb_stream_pkg.sv
// usb_stream_pkg: scheduler states and frame header layout shared by the stream mux
package usb_stream_pkg;
  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} state_t;
  localparam int HDR_CH_MSB = 7;
  localparam int HDR_CH_LSB = 4;
  localparam int HDR_LEN_MSB = 3;
  localparam int HDR_LEN_LSB = 0;
  // header byte carries the channel and the payload length minus one
  function automatic logic [7:0] make_header(input logic [3:0] ch, input logic [4:0] len);
    logic [7:0] h;
    h = '0;
    h[HDR_CH_MSB:HDR_CH_LSB] = ch;
    h[HDR_LEN_MSB:HDR_LEN_LSB] = 4'(len - 5'd1);
    return h;
  endfunction
endpackage

// File: rtl/usb_chan_fifo.sv
// usb_chan_fifo: one producer channel's byte buffer with threshold and sticky overflow flags
module usb_chan_fifo #(
  parameter int LOG_SIZE = 11,
  parameter int THRESHOLD = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          din,
  input  logic                wr,
  input  logic                rd,
  output logic [7:0]          q,
  output logic [LOG_SIZE-1:0] used,
  output logic                full,
  output logic                empty,
  output logic                have_space,
  output logic                overflow
);
  localparam logic [LOG_SIZE:0] LIMIT = (LOG_SIZE + 1)'(2 ** LOG_SIZE - THRESHOLD);
  logic [7:0] mem [2 ** LOG_SIZE];
  logic [LOG_SIZE-1:0] wp, rp;
  assign used = wp - rp;
  assign full = (wp + LOG_SIZE'(1)) == rp;
  assign empty = wp == rp;
  assign have_space = {1'b0, used} < LIMIT;
  // storage and read register carry no reset so they map onto block RAM
  always_ff @(posedge clk) begin
    if (wr && !full) mem[wp] <= din;
    if (rd && !empty) q <= mem[rp];
  end
  // pointers move on accepted accesses; a write into a full buffer is dropped and remembered
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr && !full) wp <= wp + LOG_SIZE'(1);
      if (wr && full) overflow <= 1'b1;
      if (rd && !empty) rp <= rp + LOG_SIZE'(1);
    end
endmodule

// File: rtl/usb_stream_mux.sv
// usb_stream_mux: round-robin framing of per-channel byte FIFOs onto an FT245-style write port
module usb_stream_mux
  import usb_stream_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int FIFO_LOG_SIZE = 11,
  parameter int FIFO_THRESHOLD = 8,
  parameter int MAX_BURST = 16
) (
  input  logic                mclk,
  input  logic                reset,
  input  logic [8*NUM_CH-1:0] data,
  input  logic [NUM_CH-1:0]   wr,
  output logic [NUM_CH-1:0]   have_space,
  output logic [NUM_CH-1:0]   fifo_full,
  output logic [NUM_CH-1:0]   fifo_empty,
  output logic [NUM_CH-1:0]   overflow,
  inout  wire  [7:0]          usb_d,
  input  logic                usb_rxf_n,
  input  logic                usb_txe_n,
  output logic                usb_rd_n,
  output logic                usb_oe_n,
  output logic                usb_wr_n
);
  localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  logic [7:0] q [NUM_CH];
  logic [FIFO_LOG_SIZE-1:0] used [NUM_CH];
  logic [FIFO_LOG_SIZE-1:0] grant_used;
  logic [NUM_CH-1:0] rd;
  state_t state;
  logic [CW-1:0] ch, last_grant, next_ch, cand, src_ch;
  logic [4:0] rem, burst;
  logic [7:0] hdr_q, usb_dout;
  logic any, out_hdr, just_sent, pending, slot, load;
  wire unused_rxf = usb_rxf_n;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    usb_chan_fifo #(.LOG_SIZE(FIFO_LOG_SIZE), .THRESHOLD(FIFO_THRESHOLD)) u_fifo (
      .clk(mclk), .rst(reset), .din(data[8*c +: 8]), .wr(wr[c]), .rd(rd[c]),
      .q(q[c]), .used(used[c]), .full(fifo_full[c]), .empty(fifo_empty[c]),
      .have_space(have_space[c]), .overflow(overflow[c]));
  end
  // round-robin search starting just after the last granted channel; lowest offset wins
  always_comb begin
    any = 1'b0;
    next_ch = '0;
    cand = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      cand = CW'((int'(last_grant) + i) % NUM_CH);
      if (!fifo_empty[cand]) begin
        any = 1'b1;
        next_ch = cand;
      end
    end
  end
  assign grant_used = used[next_ch];
  assign burst = grant_used >= FIFO_LOG_SIZE'(MAX_BURST) ? 5'(MAX_BURST) : 5'(grant_used);
  assign slot = (state != IDLE || pending) && !usb_txe_n;
  assign load = slot && !pending;
  assign rd = (load && state == PAYLOAD) ? NUM_CH'(1) << ch : '0;
  // both candidate bytes are registers, so the selected output only changes at a load
  assign usb_dout = out_hdr ? hdr_q : q[src_ch];
  assign usb_d = usb_dout;
  assign usb_rd_n = 1'b1;
  assign usb_oe_n = 1'b1;
  // frame FSM and write handshake; a rejected byte stays on usb_d and is strobed again
  always_ff @(posedge mclk or posedge reset)
    if (reset) begin
      state <= IDLE;
      ch <= '0;
      last_grant <= CW'(NUM_CH - 1);
      rem <= '0;
      hdr_q <= '0;
      out_hdr <= 1'b1;
      src_ch <= '0;
      usb_wr_n <= 1'b1;
      just_sent <= 1'b0;
      pending <= 1'b0;
    end else begin
      if (state == IDLE && any) begin
        state <= HEADER;
        ch <= next_ch;
        last_grant <= next_ch;
        rem <= burst;
      end
      if (slot) begin
        usb_wr_n <= 1'b0;
        just_sent <= 1'b1;
        pending <= 1'b0;
      end else begin
        usb_wr_n <= 1'b1;
        just_sent <= 1'b0;
        if (just_sent && usb_txe_n) pending <= 1'b1;
      end
      if (load && state == HEADER) begin
        hdr_q <= make_header(4'(ch), rem);
        out_hdr <= 1'b1;
        state <= PAYLOAD;
      end
      if (load && state == PAYLOAD) begin
        out_hdr <= 1'b0;
        src_ch <= ch;
        rem <= rem - 5'd1;
        if (rem == 5'd1) state <= IDLE;
      end
    end
endmodule

// File: doc/usb_stream_mux.md
# usb_stream_mux

Multi-channel successor to the single-FIFO FT2232 write streamer. Accepts bytes from NUM_CH independent producers, buffers each in its own FIFO, and drains them round-robin into the FT245-style write port as framed bursts (one header byte + up to MAX_BURST payload bytes). It keeps the FT2232 reject/retry handshake and sits between the capture/sniffer logic and the USB FIFO pins.

## Interface
- NUM_CH, 2, number of producer channels (1..16)
- FIFO_LOG_SIZE, 11, log2 of per-channel FIFO depth in bytes
- FIFO_THRESHOLD, 8, have_space deasserts when used ≥ 2**FIFO_LOG_SIZE − FIFO_THRESHOLD
- MAX_BURST, 16, max payload bytes per frame (1..16, < 2**FIFO_LOG_SIZE)
- Clocking: single clock `mclk`; `reset` is asynchronous and active-high.
- mclk  in  1  system clock, all logic on posedge
- reset  in  1  asynchronous, active-high
- data  in  8*NUM_CH  channel c byte at [8c+7:8c]
- wr  in  NUM_CH  write strobe per channel
- have_space  out  NUM_CH  per-channel threshold flag
- fifo_full  out  NUM_CH  per-channel full
- fifo_empty  out  NUM_CH  per-channel empty
- overflow  out  NUM_CH  sticky: write attempted while full
- usb_d  inout  8  driven continuously with usb_dout (write-only, never Z)
- usb_rxf_n  in  1  unused
- usb_txe_n  in  1  FT2232 transmit-ready, low = may write
- usb_rd_n  out  1  constant 1
- usb_oe_n  out  1  constant 1
- usb_wr_n  out  1  registered write strobe, active low

## Operation
- Per-channel FIFO: write when wr[c] && !fifo_full[c]; write while full is dropped and sets overflow[c] (cleared only by reset). Full = write_ptr+1 == read_ptr (capacity 2**FIFO_LOG_SIZE − 1). Pointers wrap modulo 2**FIFO_LOG_SIZE; used = write_ptr − read_ptr in FIFO_LOG_SIZE bits.
- Scheduler states: IDLE, HEADER, PAYLOAD.
- IDLE: if any channel non-empty, grant first non-empty channel searching from (last_grant+1) mod NUM_CH; latch len = min(used, MAX_BURST); go HEADER. last_grant resets to NUM_CH−1 (so channel 0 wins first).
- HEADER: when a byte slot is available, load usb_dout = {ch[3:0], (len−1)[3:0]}; go PAYLOAD.
- PAYLOAD: each slot loads usb_dout = fifo_mem[ch][read_ptr], read_ptr++, remaining−−; after last byte go IDLE. Writes during a burst never extend len.
- Byte slot: (byte to send || pending) && !usb_txe_n. In a slot: usb_wr_n←0, just_sent←1, pending←0; a new byte is loaded only if !pending. Otherwise usb_wr_n←1, just_sent←0, and if just_sent && usb_txe_n then pending←1 (usb_dout held for retry).
- Retry resends the exact rejected byte (header or payload) before anything else; state/pointers do not move on retry.
- Same-cycle write and read on one channel both take effect; full/empty evaluated on pre-update pointers.

## Timing
- Reset values: usb_wr_n=1, usb_dout=0x00, usb_rd_n=1, usb_oe_n=1, fifo_empty=all 1, fifo_full=0, have_space=all 1, overflow=0, state IDLE, pending=0, just_sent=0.
- Write-to-empty-flag: fifo_empty[c] falls one cycle after the wr edge.
- IDLE→HEADER grant takes 1 cycle; header loads on the first slot after; with usb_txe_n held low a frame of len bytes occupies len+1 consecutive usb_wr_n-low cycles, plus 1 IDLE cycle between frames.
- usb_d/usb_wr_n are registered; usb_d is stable whenever usb_wr_n is low.
- Reset mid-frame: abandons frame immediately, all FIFOs emptied; the host resynchronises on the next header.

## Structure
- Shared package usb_stream_pkg: state encoding (IDLE/HEADER/PAYLOAD), header field widths/positions (HDR_CH_MSB=7, HDR_CH_LSB=4, HDR_LEN_MSB=3, HDR_LEN_LSB=0).
- Sub-module usb_chan_fifo (one per channel, generate loop): memory, pointers, full/empty/have_space/overflow, synchronous read port with read-enable.
- Top: round-robin arbiter, frame FSM, FT2232 handshake/retry.

## Test plan
- NUM_CH=2, write 3 bytes 0xA0..0xA2 on ch0, txe_n low -> usb_d sequence 0x02,0xA0,0xA1,0xA2, 4 wr_n pulses, fifo_empty[0]=1 afterward.
- 20 bytes on ch0 and 5 on ch1 preloaded -> frames: 0x0F+16 bytes ch0, 0x14+5 bytes ch1, 0x03+4 bytes ch0.
- Raise usb_txe_n for one cycle right after a payload byte 0x55 strobe -> 0x55 retransmitted once, no byte lost or duplicated downstream.
- Fill ch1 with 2047 bytes (FIFO_LOG_SIZE=11), txe_n high -> fifo_full[1]=1, have_space[1]=0 from 2040 used; one more wr sets overflow[1], data unchanged.
- Pointer wrap: stream 5000 bytes on ch0 with txe_n toggling -> output payload matches input order exactly.
- Assert reset mid-PAYLOAD -> next cycle usb_wr_n=1, all fifo_empty=1, overflow=0; next write produces fresh header.
